// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and width helpers for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RESP = 2'd2} arb_state_t;
  typedef enum logic {OWNER_I = 1'b0, OWNER_D = 1'b1} owner_t;
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction
  localparam int BE_WIDTH = be_width(32);
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side handshake bundle.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = be_width(DATA_WIDTH);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [BW-1:0]         d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [BW-1:0]         m_be;
  logic                  m_ready;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata, m_be
  );
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/mux2x1.sv
// mux2x1: generic two-input selector, b chosen when sel is high.
module mux2x1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D), one transaction in flight.
// Define MEM_ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT consecutive D grants while I waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                busy
);
  localparam int BW = be_width(DATA_WIDTH);
  arb_state_t            state;
  owner_t                owner;
  owner_t                pick;
  logic                  any_req;
  logic                  arb;
  logic                  issue;
  logic                  rsp;
  logic                  own_d;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BW-1:0]         sel_be;
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end
  assign any_req = bus.i_req | bus.d_req;
  assign arb     = any_req && (state == IDLE || (state == WAIT_RESP && bus.m_rvalid));
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  assign pick = owner_t'(bus.d_req && !(bus.i_req && starve_cnt == CW'(STARVE_LIMIT)));
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_cnt <= '0;
    else if (arb) starve_cnt <= (pick == OWNER_I) ? '0 : bus.i_req ? starve_cnt + 1'b1 : starve_cnt;
`else
  assign pick = owner_t'(bus.d_req);
`endif
  // Owner is captured at every arbitration point so the payload mux stays fixed through a stall.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      owner <= OWNER_I;
    end else if (arb) begin
      state <= ISSUE;
      owner <= pick;
    end else if (state == ISSUE && bus.m_ready) state <= WAIT_RESP;
    else if (state == WAIT_RESP && bus.m_rvalid) state <= IDLE;
  assign issue = state == ISSUE;
  assign rsp   = state == WAIT_RESP && bus.m_rvalid;
  assign own_d = owner == OWNER_D;
  assign busy  = state != IDLE;
  mux2x1 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
    .a(bus.i_addr), .b(bus.d_addr), .sel(own_d), .y(sel_addr)
  );
  mux2x1 #(.WIDTH(DATA_WIDTH)) u_wdata_mux (
    .a({DATA_WIDTH{1'b0}}), .b(bus.d_wdata), .sel(own_d), .y(sel_wdata)
  );
  mux2x1 #(.WIDTH(BW)) u_be_mux (
    .a({BW{1'b1}}), .b(bus.d_be), .sel(own_d), .y(sel_be)
  );
  assign bus.m_req    = issue;
  assign bus.m_we     = issue & own_d & bus.d_we;
  assign bus.m_addr   = issue ? sel_addr : '0;
  assign bus.m_wdata  = issue ? sel_wdata : '0;
  assign bus.m_be     = issue ? sel_be : '0;
  assign bus.i_gnt    = issue & bus.m_ready & ~own_d;
  assign bus.d_gnt    = issue & bus.m_ready & own_d;
  assign bus.i_rvalid = rsp & ~own_d;
  assign bus.d_rvalid = rsp & own_d;
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
endmodule
